sipo_deser: RTL and testbench

- Serial-in/parallel-out deserializer.
- Accepts one width_p-bit element per clock when valid_i is high and packs depth_p consecutive accepted elements into one width_p*depth_p-bit word.
- Used wherever a narrow stream (e.g. a 1-bit serial line) must be widened into parallel words for downstream datapath logic.
- No backpressure: the block is always ready.

---
 rtl/sipo_deser_pkg.sv | 9 +
 rtl/sipo_deser_counter.sv | 26 ++
 rtl/sipo_deser.sv | 49 ++++
 tb/tb_sipo_deser.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
// sipo_deser_pkg: shared sizing helper for the deserializer and its element counter.
package sipo_deser_pkg;

    // Counter width for a modulo-depth count, never narrower than one bit.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sipo_deser_counter.sv
// sipo_deser_counter: modulo-depth_p up-counter with enable; last_o flags count == depth_p-1.
module sipo_deser_counter #(
    parameter int depth_p = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic last_o
);
    import sipo_deser_pkg::*;

    localparam int cw_lp = cnt_width(depth_p);
    localparam logic [cw_lp-1:0] max_lp = cw_lp'(depth_p - 1);

    logic [cw_lp-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_cnt <= '0;
        else if (en_i)
            r_cnt <= last_o ? '0 : r_cnt + cw_lp'(1);
    end

    assign last_o = (r_cnt == max_lp);

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: packs depth_p accepted width_p-bit elements into one word, first element in the LSBs.
module sipo_deser #(
    parameter int width_p = 1,
    parameter int depth_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       valid_o,
    output logic [width_p*depth_p-1:0] data_o
);
    localparam int word_width_lp = width_p * depth_p;

    logic                     w_last;
    logic [word_width_lp-1:0] w_next;
    logic [word_width_lp-1:0] r_shift;
    logic [word_width_lp-1:0] r_data;
    logic                     r_valid;

    sipo_deser_counter #(.depth_p(depth_p)) u_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (valid_i),
        .last_o (w_last)
    );

    // Elements enter at the top and drift down, so after depth_p accepts the first sits in the LSBs.
    assign w_next = {data_i, r_shift[word_width_lp-1:width_p]};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= valid_i && w_last;
            if (valid_i) begin
                r_shift <= w_next;
                if (w_last)
                    r_data <= w_next;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: scoreboard bench; a list-based model predicts each completed word and its cycle.
module tb_sipo_deser;
    localparam int W = 1;
    localparam int D = 8;

    typedef struct {
        logic [W*D-1:0] word;
        int             cyc;
    } exp_t;

    logic           clk = 0;
    logic           reset_i = 0;
    logic           valid_i = 0;
    logic [W-1:0]   data_i = '0;
    logic           valid_o;
    logic [W*D-1:0] data_o;

    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    int             pulses = 0;
    logic [W*D-1:0] last_word = '0;
    logic [W-1:0]   part[$];
    exp_t           sb[$];

    sipo_deser #(.width_p(W), .depth_p(D)) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .valid_i(valid_i),
        .data_i (data_i),
        .valid_o(valid_o),
        .data_o (data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: collect accepted elements in a list; a full list becomes a word with element k at bits k*W.
    task automatic accept(input logic [W-1:0] d);
        logic [W*D-1:0] w;
        part.push_back(d);
        if (part.size() == D) begin
            w = '0;
            for (int k = 0; k < D; k++)
                w = w | ((W*D)'(part[k]) << (k * W));
            sb.push_back('{w, cyc + 1});
            part.delete();
        end
    endtask

    task automatic send(input bit v, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        valid_i = v;
        data_i  = v ? d : 'x;
        if (v) accept(d);
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, '0);
    endtask

    task automatic send_seq(input bit s[D]);
        for (int k = 0; k < D; k++) send(1'b1, W'(s[k]));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_i = 0;
        valid_i = 0;
        part.delete();
        sb.delete();
        last_word = '0;
        #1;
        chk("async_rst_data", 32'(data_o), 32'h0);
        chk("async_rst_valid", 32'(valid_o), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1;
    endtask

    // Monitor: every pulse must match the oldest prediction in value and cycle; otherwise data_o must hold.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_word: expected %h at cycle %0d, no pulse by cycle %0d", sb[0].word, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        total++;
        if (valid_o) begin
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: data_o=%h at cycle %0d, no word predicted", data_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                pulses++;
                if (data_o !== e.word || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL word: got %h at cycle %0d expected %h at cycle %0d", data_o, cyc, e.word, e.cyc);
                end
                last_word = e.word;
            end
        end else if (data_o !== last_word) begin
            bad++;
            $display("FAIL hold: data_o=%h expected %h at cycle %0d", data_o, last_word, cyc);
        end
    end

    initial begin
        int p0;
        repeat (10) @(posedge clk);
        #1;
        chk("reset_data", 32'(data_o), 32'h0);
        chk("reset_valid", 32'(valid_o), 32'h0);
        reset_i = 1;

        send_seq('{0, 1, 1, 0, 1, 0, 0, 0});
        idle(2);
        chk("single_word", 32'(data_o), 32'h16);
        idle(20);
        chk("single_hold", 32'(data_o), 32'h16);

        p0 = pulses;
        send(1, 1); send(1, 0); send(1, 1);
        idle(5);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0); send(1, 1);
        idle(2);
        chk("gapped_word", 32'(data_o), 32'h85);
        chk("gapped_pulses", 32'(pulses - p0), 32'd1);

        send_seq('{1, 0, 1, 0, 0, 0, 0, 1});
        idle(2);
        chk("seq_word1", 32'(data_o), 32'h85);
        send_seq('{0, 1, 0, 1, 1, 1, 0, 1});
        idle(2);
        chk("seq_word2", 32'(data_o), 32'hBA);
        send_seq('{0, 1, 1, 0, 1, 0, 0, 0});
        idle(2);
        chk("seq_word3", 32'(data_o), 32'h16);

        p0 = pulses;
        for (int i = 0; i < 16; i++) send(1'b1, W'($urandom));
        idle(2);
        chk("b2b_pulses", 32'(pulses - p0), 32'd2);

        for (int i = 0; i < 4; i++) send(1'b1, 1'b1);
        async_reset();
        send_seq('{1, 1, 0, 0, 0, 0, 1, 0});
        idle(2);
        chk("post_reset_word", 32'(data_o), 32'h43);

        for (int i = 0; i < 400; i++)
            send($urandom_range(0, 9) < 6, W'($urandom));
        idle(3);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
